// File: rtl/circuit_src_if.sv
// circuit_src_if: control and sample bus between a burst stimulus source and its user.
// master: drives start/stop/config, observes en/x/busy/done/count.
// slave : the source itself (circuit_src).
interface circuit_src_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  num_samples;
  logic [7:0]        gap;
  logic [DATA_W-1:0] seed;
  logic              en;
  logic [DATA_W-1:0] x;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;

  modport master (
    output start, stop, num_samples, gap, seed,
    input  en, x, busy, done, count
  );

  modport slave (
    input  start, stop, num_samples, gap, seed,
    output en, x, busy, done, count
  );
endinterface

// File: rtl/circuit_src.sv
// circuit_src: burst stimulus source emitting pseudo-random signed samples with single-cycle
// en strobes separated by a programmable idle gap (sample = Galois LFSR value % MOD).
// Ports: clk, rst (sync, active-high), bus (circuit_src_if.slave: start/stop/config in,
// en/x/busy/done/count out). All outputs registered; first strobe two edges after start.
module circuit_src #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int MOD    = 20
) (
  input  logic           clk,
  input  logic           rst,
  circuit_src_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, EMIT, GAP, FIN} state_t;

  // Remainder is taken at the wider of 32 bits and DATA_W so MOD always fits.
  localparam int EXT_W = (DATA_W > 32) ? DATA_W : 32;
  localparam logic signed [EXT_W-1:0] MOD_S = EXT_W'(MOD);
  localparam logic [31:0] POLY = 32'h8020_0003;

  state_t           state;
  logic [31:0]      lfsr;
  logic [CNT_W-1:0] n_cfg;
  logic [7:0]       gap_cfg;
  logic [7:0]       gap_cnt;

  logic [31:0]             lfsr_n;
  logic signed [EXT_W-1:0] lfsr_ext;
  logic signed [EXT_W-1:0] rem;
  logic [CNT_W-1:0]        cnt_inc;
  logic [31:0]             seed32;

  always_comb begin
    lfsr_n = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
    // Signed operands: % truncates toward zero, remainder takes the dividend's sign.
    lfsr_ext = EXT_W'($signed(lfsr_n));
    rem      = lfsr_ext % MOD_S;
    cnt_inc  = bus.count + 1'b1;
    seed32   = 32'(bus.seed);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= 32'd1;
      n_cfg     <= '0;
      gap_cfg   <= '0;
      gap_cnt   <= '0;
      bus.en    <= 1'b0;
      bus.x     <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.count <= '0;
    end else begin
      // Strobe and done are single-cycle unless re-asserted below.
      bus.en   <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            n_cfg     <= bus.num_samples;
            gap_cfg   <= bus.gap;
            lfsr      <= (seed32 == 32'd0) ? 32'd1 : seed32;
            bus.count <= '0;
            bus.busy  <= 1'b1;
            state     <= (bus.num_samples != '0) ? EMIT : FIN;
          end
        end
        EMIT: begin
          if (bus.stop) begin
            state <= FIN;
          end else begin
            lfsr      <= lfsr_n;
            bus.x     <= DATA_W'(rem);
            bus.en    <= 1'b1;
            bus.count <= cnt_inc;
            if (cnt_inc == n_cfg) begin
              state <= FIN;
            end else if (gap_cfg == 8'd0) begin
              state <= EMIT;
            end else begin
              gap_cnt <= gap_cfg;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (bus.stop) begin
            state <= FIN;
          end else if (gap_cnt <= 8'd1) begin
            state <= EMIT;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        FIN: begin
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circuit_src.sv
module tb_circuit_src;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int MOD    = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  circuit_src_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  circuit_src #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MOD(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observations of one burst, cycle 1 = first cycle after the start edge.
  int obs_x[$];
  int obs_cyc[$];
  int exp_x[$];
  int done_cyc;
  int done_len;
  int busy_bad;
  int x_bad;

  function automatic int unsigned lfsr_next(input int unsigned v);
    if (v % 2 == 1) return (v / 2) ^ 32'h8020_0003;
    return v / 2;
  endfunction

  // Symmetric remainder: magnitude of |v| mod MOD, sign of v.
  function automatic int fold(input int unsigned v);
    longint sv;
    sv = longint'($signed(v));
    if (sv < 0) return -int'((-sv) % MOD);
    return int'(sv % MOD);
  endfunction

  task automatic build_model(input int unsigned seed, input int n);
    int unsigned s;
    exp_x.delete();
    s = (seed == 0) ? 1 : seed;
    for (int i = 0; i < n; i++) begin
      s = lfsr_next(s);
      exp_x.push_back(fold(s));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one burst and records strobes, done timing and busy/x behaviour.
  task automatic run_burst(input int n, input int g, input int unsigned seed,
                           input int stop_at, input bit poke);
    int budget;
    logic [DATA_W-1:0] prev_x;
    obs_x.delete();
    obs_cyc.delete();
    done_cyc = -1;
    done_len = 0;
    busy_bad = 0;
    x_bad    = 0;
    bus.num_samples = CNT_W'(n);
    bus.gap         = 8'(g);
    bus.seed        = seed;
    bus.stop        = 1'b0;
    bus.start       = 1'b1;
    prev_x = bus.x;
    tick();
    bus.start = 1'b0;
    budget = 2 + n + ((n > 0) ? (n - 1) * g : 0) + 20;
    for (int c = 1; c <= budget; c++) begin
      bus.stop = 1'b0;
      if (poke) begin
        bus.start       = (c >= 3 && c <= 5);
        bus.seed        = $urandom;
        bus.num_samples = 16'd7;
      end
      if (bus.en === 1'b1) begin
        obs_x.push_back(int'($signed(bus.x)));
        obs_cyc.push_back(c);
      end else if (bus.x !== prev_x) begin
        x_bad++;
      end
      prev_x = bus.x;
      if (bus.done === 1'b1) begin
        if (done_cyc < 0) done_cyc = c;
        done_len++;
      end
      if (done_cyc < 0 && bus.busy !== 1'b1) busy_bad++;
      if (done_cyc >= 0 && bus.busy !== 1'b0) busy_bad++;
      if (stop_at > 0 && bus.en === 1'b1 && obs_x.size() == stop_at) bus.stop = 1'b1;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      tick();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.num_samples = 16'd5;
    bus.gap = 8'd0;
    bus.seed = 32'd1;
    bus.stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.start = i[0];
      tick();
      checks++;
      if ({bus.en, bus.busy, bus.done} !== 3'b000 || bus.x !== '0 || bus.count !== '0) begin
        errors++;
        $display("FAIL reset cycle %0d: en=%b busy=%b done=%b x=%0d count=%0d, required all 0",
                 i, bus.en, bus.busy, bus.done, bus.x, bus.count);
      end
    end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    build_model(1, 2);
    run_burst(2, 1, 1, 0, 1'b0);
    checks++;
    if (obs_x.size() != 2) begin
      errors++; $display("FAIL basic strobes: got %0d required 2", obs_x.size());
    end else begin
      checks++;
      if (obs_x[0] != -13 || obs_x[1] != -14) begin
        errors++; $display("FAIL basic x: got %0d,%0d required -13,-14", obs_x[0], obs_x[1]);
      end
      checks++;
      if (obs_x[0] != exp_x[0] || obs_x[1] != exp_x[1]) begin
        errors++; $display("FAIL basic model x: got %0d,%0d required %0d,%0d",
                           obs_x[0], obs_x[1], exp_x[0], exp_x[1]);
      end
      checks++;
      if (obs_cyc[0] != 2 || obs_cyc[1] != 4) begin
        errors++; $display("FAIL basic strobe cycles: got %0d,%0d required 2,4", obs_cyc[0], obs_cyc[1]);
      end
    end
    checks++;
    if (done_cyc != 5 || done_len != 1) begin
      errors++; $display("FAIL basic done: cycle %0d len %0d required cycle 5 len 1", done_cyc, done_len);
    end
    checks++;
    if (bus.count !== 16'd2 || busy_bad != 0 || x_bad != 0) begin
      errors++; $display("FAIL basic count/busy/x: count %0d busy_bad %0d x_bad %0d required 2,0,0",
                         bus.count, busy_bad, x_bad);
    end
  endtask

  task automatic test_long();
    int range_bad = 0;
    int model_bad = 0;
    int gap_bad = 0;
    build_model(0, 100);
    run_burst(100, 1, 0, 0, 1'b0);
    checks++;
    if (obs_x.size() != 100) begin
      errors++; $display("FAIL long strobes: got %0d required 100", obs_x.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        if (obs_x[i] < -19 || obs_x[i] > 19) range_bad++;
        if (obs_x[i] != exp_x[i]) model_bad++;
        if (obs_cyc[i] != 2 + 2 * i) gap_bad++;
      end
      checks++;
      if (obs_x[0] != -13) begin
        errors++; $display("FAIL long first x: got %0d required -13", obs_x[0]);
      end
      checks++;
      if (range_bad != 0 || model_bad != 0 || gap_bad != 0) begin
        errors++; $display("FAIL long samples: out-of-range %0d, model mismatches %0d, timing %0d, required 0",
                           range_bad, model_bad, gap_bad);
      end
    end
    checks++;
    if (done_cyc != 2 + 100 + 99 || done_len != 1 || bus.count !== 16'd100) begin
      errors++; $display("FAIL long done: cycle %0d len %0d count %0d required 201,1,100",
                         done_cyc, done_len, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int unsigned sd;
    sd = $urandom;
    build_model(sd, 4);
    run_burst(4, 0, sd, 0, 1'b0);
    checks++;
    if (obs_x.size() != 4) begin
      errors++; $display("FAIL b2b strobes: got %0d required 4", obs_x.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (obs_cyc[i] != 2 + i || obs_x[i] != exp_x[i]) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL b2b sequence: %0d wrong strobes, required 0", bad);
      end
    end
    checks++;
    if (done_cyc != 6 || busy_bad != 0 || bus.count !== 16'd4) begin
      errors++; $display("FAIL b2b done: cycle %0d busy_bad %0d count %0d required 6,0,4",
                         done_cyc, busy_bad, bus.count);
    end
  endtask

  task automatic test_zero();
    run_burst(0, 3, 5, 0, 1'b0);
    checks++;
    if (obs_x.size() != 0 || done_cyc != 2 || done_len != 1 || bus.count !== 16'd0) begin
      errors++; $display("FAIL zero: strobes %0d done cycle %0d len %0d count %0d required 0,2,1,0",
                         obs_x.size(), done_cyc, done_len, bus.count);
    end
  endtask

  task automatic test_stop();
    int unsigned sd;
    int bad = 0;
    sd = $urandom;
    build_model(sd, 10);
    run_burst(10, 2, sd, 3, 1'b1);
    checks++;
    if (obs_x.size() != 3) begin
      errors++; $display("FAIL stop strobes: got %0d required 3", obs_x.size());
    end else begin
      for (int i = 0; i < 3; i++)
        if (obs_x[i] != exp_x[i] || obs_cyc[i] != 2 + 3 * i) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL stop sequence: %0d wrong strobes, required 0", bad);
      end
      checks++;
      if (done_cyc != obs_cyc[2] + 2 || done_len != 1) begin
        errors++; $display("FAIL stop done: cycle %0d len %0d required %0d,1", done_cyc, done_len, obs_cyc[2] + 2);
      end
    end
    checks++;
    if (bus.count !== 16'd3 || busy_bad != 0) begin
      errors++; $display("FAIL stop count: count %0d busy_bad %0d required 3,0", bus.count, busy_bad);
    end
  endtask

  task automatic test_mid_reset();
    int seen = 0;
    int late = 0;
    bus.num_samples = 16'd10;
    bus.gap = 8'd1;
    bus.seed = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (bus.en === 1'b1) seen = 1;
      else tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (seen == 0 || {bus.en, bus.busy, bus.done} !== 3'b000 || bus.x !== '0 || bus.count !== '0) begin
      errors++; $display("FAIL mid reset: seen %0d en=%b busy=%b done=%b x=%0d count=%0d, required strobe then all 0",
                         seen, bus.en, bus.busy, bus.done, bus.x, bus.count);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) late++;
    end
    checks++;
    if (late != 0) begin
      errors++; $display("FAIL mid reset quiet: %0d active cycles after reset, required 0", late);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      int n, g, bad;
      int unsigned sd;
      n  = $urandom_range(1, 20);
      g  = $urandom_range(0, 4);
      sd = $urandom;
      bad = 0;
      build_model(sd, n);
      run_burst(n, g, sd, 0, 1'b0);
      if (obs_x.size() == n) begin
        for (int i = 0; i < n; i++)
          if (obs_x[i] != exp_x[i] || obs_cyc[i] != 2 + i * (g + 1)) bad++;
      end else begin
        bad = 1000;
      end
      checks++;
      if (bad != 0 || done_cyc != 2 + n + (n - 1) * g || done_len != 1 ||
          bus.count !== CNT_W'(n) || busy_bad != 0 || x_bad != 0) begin
        errors++; $display("FAIL random burst %0d (n=%0d gap=%0d): strobes %0d bad %0d done %0d/%0d count %0d busy_bad %0d x_bad %0d, required done %0d",
                           k, n, g, obs_x.size(), bad, done_cyc, done_len, bus.count, busy_bad, x_bad,
                           2 + n + (n - 1) * g);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.num_samples = '0;
    bus.gap = '0;
    bus.seed = '0;
    rst = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_long();
    test_back_to_back();
    test_zero();
    test_stop();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/circuit_src.md
# circuit_src

Synthesizable stimulus source for the `circuit` datapath: drives the `en`/`x` input pair with a burst of pseudo-random signed samples, one single-cycle `en` strobe per sample with a programmable idle gap. It replaces the behavioural stimulus loop so the same traffic can be generated on FPGA and in simulation. Samples are produced from a 32-bit Galois LFSR reduced to the range -(MOD-1)..+(MOD-1).

## Interface
- `DATA_W`, 32, sample width of `x`
- `CNT_W`, 16, width of sample counter and `num_samples`
- `MOD`, 20, modulus applied to the signed LFSR value; must be 2..2^(DATA_W-1)-1

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to begin a burst; ignored while `busy`
- `stop`  in  1  abort current burst; takes priority over `start`
- `num_samples`  in  CNT_W  samples per burst, captured on accepted `start`
- `gap`  in  8  idle cycles between strobes, captured on accepted `start`
- `seed`  in  DATA_W  LFSR seed, captured on accepted `start`; 0 is replaced by 1
- `en`  out  1  sample strobe to `circuit`
- `x`  out  DATA_W  sample value, two's complement
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse at burst end (normal or aborted)
- `count`  out  CNT_W  samples emitted in current/last burst

## Operation
- FSM states: IDLE, EMIT, GAP, FIN.
- IDLE: `start`=1 and `stop`=0 -> latch config, `count`<=0, `busy`<=1; go EMIT if `num_samples`!=0, else FIN.
- EMIT (one cycle): `lfsr_n` = Galois step of `lfsr` (shift right; if old bit0=1, XOR 0x80200003); `lfsr`<=`lfsr_n`; `x`<=$signed(`lfsr_n`) % MOD with truncation toward zero (sign follows dividend); `en`<=1; `count`<=`count`+1. If `count`+1 == `num_samples` -> FIN; else if `gap`==0 -> EMIT; else GAP with gap counter loaded to `gap`.
- GAP: `en`=0, decrement gap counter; at 1 -> EMIT.
- FIN (one cycle): `done`<=1, `busy`<=0, then IDLE.
- `stop` in EMIT or GAP: next state FIN; no further strobes; an `en` already registered completes its single cycle.
- `x` holds its last value when `en`=0; never changes except on a strobe.
- `start` while `busy` is ignored; `start` in the FIN cycle is ignored (accepted from IDLE only).
- `count` holds after burst until next accepted `start`.

## Timing
- Reset values: `en`=0, `x`=0, `busy`=0, `done`=0, `count`=0, LFSR=1, state IDLE.
- Registered outputs only; no combinational path input->output.
- `start` accepted at edge N -> `busy`=1 after N; first `en`=1 after N+1 (latency 2 edges).
- Strobe period = `gap`+1 cycles; `gap`=1 reproduces alternating en=1/en=0.
- Last strobe at edge M -> `done`=1 and `busy`=0 after M+1; `done` lasts exactly one cycle.
- `rst` mid-burst: all outputs to reset values next edge, no `done` pulse.
- Burst of N samples occupies 2 + N + (N-1)·`gap` cycles from `start` to `done`.

## Test plan
- Reset: hold `rst` 3 cycles while toggling `start` -> `en`,`x`,`busy`,`done`,`count` all 0, no strobe.
- Seed 1, `num_samples`=2, `gap`=1: strobes 2 cycles apart; `x`=0xFFFFFFF3 (-13) then 0xFFFFFFF2 (-14); `done` one cycle after second strobe; `count`=2.
- `num_samples`=100, `gap`=1, seed 0: 100 strobes, every `x` in -19..19, first `x`=-13 (seed 0->1), `done` at cycle 2+100+99 after `start`.
- `gap`=0, `num_samples`=4: `en` high 4 consecutive cycles, `x` changes each cycle, `busy` falls with `done`.
- `num_samples`=0: no `en`; `done` pulse 2 cycles after `start`, `count`=0.
- `stop` after 3rd strobe of 10 (`gap`=2): no 4th strobe, `done` next cycle, `count`=3; `start` during burst has no effect on strobe sequence.
